// File: rtl/lmg_move_packer.sv
// lmg_move_packer: resets the LMG, drains its FIFO and compacts valid moves into
// consecutive RAM words, followed by a count/overflow header and a zero terminator.
module lmg_move_packer #(
    parameter int SLOTS     = 8,
    parameter int MOVE_W    = 18,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 16,
    parameter int CNT_W     = 8,
    parameter int MAX_MOVES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [CNT_W-1:0]          move_count,
    output logic                      lmg_reset,
    input  logic                      lmg_done,
    input  logic                      lmg_fifo_empty,
    output logic                      lmg_rden,
    input  logic [SLOTS*(MOVE_W+1)-1:0] lmg_fifo_out,
    output logic                      ram_wren,
    output logic [ADDR_W-1:0]         ram_wraddr,
    output logic [DATA_W-1:0]         ram_data
);
    localparam int SW = MOVE_W + 1;
    localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [3:0] {IDLE, LMG_RST, WAIT_DONE, POP, LATCH, SCAN, HDR, TERM, DONE} state_t;

    state_t state, stateN;
    logic startQ, rstCnt, rstCntN;
    logic [SLOTS*SW-1:0] wordQ, wordN;
    logic [IW-1:0] slotIdx, slotN;
    logic [CNT_W-1:0] cntN;
    logic overflowN, busyN, doneN, lmgResetN, lmgRdenN, ramWrenN;
    logic [ADDR_W-1:0] ramWraddrN, nextAddr;
    logic [DATA_W-1:0] ramDataN;
    logic [SW-1:0] slot;
    logic allInvalid, stopScan;

    assign slot     = wordQ[slotIdx*SW +: SW];
    assign nextAddr = ADDR_W'(BASE_ADDR + 1) + ADDR_W'(move_count);
    assign stopScan = allInvalid || lmg_fifo_empty;

    always_comb begin
        allInvalid = 1'b1;
        for (int k = 0; k < SLOTS; k++) allInvalid = allInvalid & wordQ[k*SW+MOVE_W];
    end

    // Every output is the registered image of its next value, so writes appear one cycle after the state that issues them.
    always_comb begin
        stateN     = state;
        wordN      = wordQ;
        slotN      = slotIdx;
        rstCntN    = rstCnt;
        cntN       = move_count;
        overflowN  = overflow;
        busyN      = busy;
        doneN      = done;
        lmgResetN  = 1'b0;
        lmgRdenN   = 1'b0;
        ramWrenN   = 1'b0;
        ramWraddrN = ram_wraddr;
        ramDataN   = ram_data;
        case (state)
            IDLE: if (start && !startQ) begin
                stateN    = LMG_RST;
                cntN      = '0;
                overflowN = 1'b0;
                doneN     = 1'b0;
                busyN     = 1'b1;
                lmgResetN = 1'b1;
                rstCntN   = 1'b0;
            end
            LMG_RST: begin
                rstCntN   = 1'b1;
                lmgResetN = !rstCnt;
                stateN    = rstCnt ? WAIT_DONE : LMG_RST;
            end
            WAIT_DONE: if (lmg_done) begin
                stateN   = lmg_fifo_empty ? HDR : POP;
                lmgRdenN = !lmg_fifo_empty;
            end
            POP: stateN = LATCH;
            LATCH: begin
                wordN  = lmg_fifo_out;
                slotN  = '0;
                stateN = SCAN;
            end
            SCAN: begin
                if (!slot[MOVE_W]) begin
                    if (move_count < CNT_W'(MAX_MOVES)) begin
                        ramWrenN   = 1'b1;
                        ramWraddrN = nextAddr;
                        ramDataN   = DATA_W'(slot[MOVE_W-1:0]);
                        cntN       = move_count + 1'b1;
                    end else begin
                        overflowN = 1'b1;
                    end
                end
                slotN = slotIdx + 1'b1;
                if (slotIdx == IW'(SLOTS - 1)) begin
                    stateN   = stopScan ? HDR : POP;
                    lmgRdenN = !stopScan;
                end
            end
            HDR: begin
                ramWrenN   = 1'b1;
                ramWraddrN = ADDR_W'(BASE_ADDR);
                ramDataN   = DATA_W'({overflow, move_count});
                stateN     = TERM;
            end
            TERM: begin
                ramWrenN   = 1'b1;
                ramWraddrN = nextAddr;
                ramDataN   = '0;
                stateN     = DONE;
            end
            DONE: begin
                doneN  = 1'b1;
                busyN  = 1'b0;
                stateN = IDLE;
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            startQ     <= 1'b0;
            rstCnt     <= 1'b0;
            wordQ      <= '0;
            slotIdx    <= '0;
            move_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lmg_reset  <= 1'b0;
            lmg_rden   <= 1'b0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= '0;
        end else begin
            state      <= stateN;
            startQ     <= start;
            rstCnt     <= rstCntN;
            wordQ      <= wordN;
            slotIdx    <= slotN;
            move_count <= cntN;
            overflow   <= overflowN;
            busy       <= busyN;
            done       <= doneN;
            lmg_reset  <= lmgResetN;
            lmg_rden   <= lmgRdenN;
            ram_wren   <= ramWrenN;
            ram_wraddr <= ramWraddrN;
            ram_data   <= ramDataN;
        end
    end
endmodule

// File: doc/lmg_move_packer.md
Name: lmg_move_packer

Overview:
- Parametrised successor to the fixed 8-slot LMG-to-RAM copy logic in the Avalon control block.
- On start, resets the LMG and waits for lmg_done. It then pops FIFO words of SLOTS packed moves, compacts the valid moves into consecutive block-RAM words, and writes a count header and a zero terminator.
- Sits between the LMG instance and the RAM write port of the control block. The control block muxes its own Avalon writes against this block's ram_wren.

Parameters:
SLOTS, 8, move slots per LMG FIFO word
MOVE_W, 18, move payload bits per slot (slot is MOVE_W+1 bits incl. invalid flag)
ADDR_W, 15, RAM address width
DATA_W, 32, RAM data width (must be >= MOVE_W+1 and >= CNT_W+1)
BASE_ADDR, 16, header address; moves start at BASE_ADDR+1
CNT_W, 8, move counter width
MAX_MOVES, 255, max moves stored (<= 2^CNT_W-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; rising edge (start=1 while start_q=0) launches a run
busy  out  1  high from accepted start until DONE
done  out  1  run complete; held until next accepted start or reset
overflow  out  1  valid moves were dropped at MAX_MOVES
move_count  out  CNT_W  moves stored this run
lmg_reset  out  1  reset to LMG
lmg_done  in  1  LMG generation finished
lmg_fifo_empty  in  1  LMG FIFO empty
lmg_rden  out  1  LMG FIFO pop; data valid on lmg_fifo_out the following cycle
lmg_fifo_out  in  SLOTS*(MOVE_W+1)  slot k = bits [k*(MOVE_W+1)+MOVE_W : k*(MOVE_W+1)]; MSB of slot = invalid (1 = invalid)
ram_wren  out  1  RAM write strobe
ram_wraddr  out  ADDR_W  RAM write address
ram_data  out  DATA_W  RAM write data

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; counters, slot index and flags cleared. A reset mid-run aborts with no further RAM writes.
- All outputs registered. start_q is a registered copy of start.
- IDLE: on a start rising edge, clear move_count, overflow and done, set busy, go to LMG_RST. A start edge in any other state is ignored.
- LMG_RST: lmg_reset=1 for exactly 2 cycles, then WAIT_DONE.
- WAIT_DONE: wait for lmg_done=1.
  - If lmg_fifo_empty=1, go to HDR.
  - Otherwise go to POP.
- POP: lmg_rden=1 for one cycle, then LATCH.
- LATCH: capture lmg_fifo_out into word_q, set slot index=0, go to SCAN.
- SCAN: one slot per cycle, slot 0 first.
  - Valid slot and move_count<MAX_MOVES: ram_wren=1, ram_wraddr=BASE_ADDR+1+move_count, ram_data=zero-extended MOVE_W payload; move_count++.
  - Valid slot and move_count==MAX_MOVES: no write; overflow=1.
  - Invalid slot: no write.
  - Each SCAN visit takes exactly one cycle, so a word takes SLOTS cycles.
- After slot SLOTS-1:
  - If all SLOTS invalid flags in word_q were 1 → HDR.
  - Else if lmg_fifo_empty=1 → HDR.
  - Else → POP.
- HDR: one write at ram_wraddr=BASE_ADDR, ram_data={overflow at bit CNT_W, move_count zero-extended}.
- TERM: one write at ram_wraddr=BASE_ADDR+1+move_count, ram_data=0.
- DONE: done=1, busy=0, return to IDLE. done stays high until the next accepted start.
- ram_wren is high only in SCAN (valid, stored slot), HDR and TERM. At most one write per cycle.
- Address arithmetic is ADDR_W bits wide and wraps silently. Integrators keep BASE_ADDR+1+MAX_MOVES < 2^ADDR_W.
- Latency, non-empty FIFO with N words: 2 (LMG_RST) + wait + N*(SLOTS+2) + 3 (HDR, TERM, DONE) cycles after lmg_done.

Test Plan:
- Reset mid-SCAN with 3 moves already written → all outputs 0 next sample; no further ram_wren; subsequent start runs cleanly from move_count=0.
- SLOTS=8, one word with slots 0,2,5 valid (payloads 0x101,0x202,0x305), then an all-invalid word → writes 0x101@17, 0x202@18, 0x305@19, header 3@16, 0@20; done=1, move_count=3, overflow=0.
- lmg_done with lmg_fifo_empty=1 immediately → no pops; writes 0@16 and 0@17; done=1.
- MAX_MOVES=4, two full-valid words then empty FIFO → 4 move writes @17–20, header 0x104@16 (overflow bit 8 set), terminator @21; overflow=1.
- Start pulsed again while busy, then after done → first re-pulse ignored; second clears done/count and re-asserts lmg_reset for exactly 2 cycles.
- SLOTS=4, MOVE_W=12, BASE_ADDR=100 → slot 3 decoded from bits [51:39]; first move written @101, header @100.
